pipeline_hazard_ctrl: RTL and testbench

//  Sequencing controller for the 5-stage F/D/X/M/W pipeline. Consumes stallF_req from the forwarding

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_valid_chain.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the F/D/X/M/W pipeline sequencing controller:
// FSM state encodings, stage indices and the valid-chain control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR      = 2'd3;

    localparam int STG_F   = 0;
    localparam int STG_D   = 1;
    localparam int STG_X   = 2;
    localparam int STG_M   = 3;
    localparam int STG_W   = 4;
    localparam int NUM_STG = 5;

    typedef struct packed {
        logic clear;   // drop every valid bit
        logic adv;     // shift D->X->M->W
        logic ld_d;    // load validD from d_in
        logic d_in;
        logic ld_f;    // load validF from f_in
        logic f_in;
    } chain_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath/forwarding unit and the sequencing controller.
// The controller takes the slave side; the core top (or a bench) takes the master side.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run_en;
    logic             imem_ready;
    logic             stallF_req;
    logic             redirect_req;
    logic             dmem_busy;
    logic             pc_en;
    logic             pc_sel_redir;
    logic             enF, enD, enX, enM, enW;
    logic             validF, validD, validX, validM, validW;
    logic [1:0]       state_o;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output run_en, imem_ready, stallF_req, redirect_req, dmem_busy,
        input  pc_en, pc_sel_redir, enF, enD, enX, enM, enW,
               validF, validD, validX, validM, validW,
               state_o, err_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  run_en, imem_ready, stallF_req, redirect_req, dmem_busy,
        output pc_en, pc_sel_redir, enF, enD, enX, enM, enW,
               validF, validD, validX, validM, validW,
               state_o, err_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_valid_chain.sv
// Five stage-valid flops (F..W) with independent advance, load and clear controls.
module pipe_valid_chain
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  chain_ctrl_t        ctrl,
    output logic [NUM_STG-1:0] valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (ctrl.clear) begin
            valid <= '0;
        end else begin
            if (ctrl.adv) begin
                valid[STG_W] <= valid[STG_M];
                valid[STG_M] <= valid[STG_X];
                valid[STG_X] <= valid[STG_D];
            end
            if (ctrl.ld_d) valid[STG_D] <= ctrl.d_in;
            if (ctrl.ld_f) valid[STG_F] <= ctrl.f_in;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: FSM, hazard priority and PC control.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [8:0] TMO = 9'(MEM_TIMEOUT);

    logic [1:0]         state, state_nx;
    logic [7:0]         wait_cnt, wait_nx;
    logic [8:0]         busy_cnt;
    logic               en_f, en_dxmw, pc_en, pc_sel, redir_acc;
    logic               err_q;
    chain_ctrl_t        ctrl;
    logic [NUM_STG-1:0] valid;

    // Priority in RUN (and MEM_WAIT once busy drops): busy > redirect > stall > normal.
    always_comb begin
        state_nx  = state;
        wait_nx   = wait_cnt;
        busy_cnt  = 9'd0;
        en_f      = 1'b0;
        en_dxmw   = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        redir_acc = 1'b0;
        ctrl      = '0;
        case (state)
            ST_IDLE: begin
                if (bus.run_en) state_nx = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (bus.dmem_busy) begin
                    busy_cnt = (state == ST_RUN) ? 9'd1 : ({1'b0, wait_cnt} + 9'd1);
                    wait_nx  = busy_cnt[7:0];
                    state_nx = (busy_cnt >= TMO) ? ST_ERR : ST_MEM_WAIT;
                end else begin
                    state_nx  = ST_RUN;
                    wait_nx   = 8'd0;
                    en_dxmw   = 1'b1;
                    ctrl.adv  = 1'b1;
                    ctrl.ld_d = 1'b1;
                    if (bus.redirect_req) begin
                        en_f      = 1'b1;
                        pc_en     = 1'b1;
                        pc_sel    = 1'b1;
                        redir_acc = 1'b1;
                        ctrl.ld_f = 1'b1;
                    end else if (!bus.stallF_req) begin
                        en_f      = 1'b1;
                        pc_en     = bus.imem_ready;
                        ctrl.ld_f = 1'b1;
                        ctrl.f_in = bus.imem_ready;
                        ctrl.d_in = valid[STG_F] & bus.imem_ready;
                    end
                end
            end
            default: ;
        endcase
        if (state_nx == ST_ERR) ctrl.clear = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (state_nx == ST_ERR) err_q <= 1'b1;
        end
    end

    pipe_valid_chain u_valid_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl),
        .valid (valid)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             in_run;

    assign in_run = (state == ST_RUN) || (state == ST_MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (in_run && !en_f) stall_q <= stall_q + 1'b1;
            if (redir_acc)       flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif

    assign bus.pc_en        = pc_en;
    assign bus.pc_sel_redir = pc_sel;
    assign bus.enF          = en_f;
    assign bus.enD          = en_dxmw;
    assign bus.enX          = en_dxmw;
    assign bus.enM          = en_dxmw;
    assign bus.enW          = en_dxmw;
    assign bus.validF       = valid[STG_F];
    assign bus.validD       = valid[STG_D];
    assign bus.validX       = valid[STG_X];
    assign bus.validM       = valid[STG_M];
    assign bus.validW       = valid[STG_W];
    assign bus.state_o      = state;
    assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle model queues expected outputs as each
// stimulus cycle is driven; they are popped and compared when the DUT produces them.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 16;
    localparam int CW  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] en;      // {W,M,X,D,F}
        logic       pc_en;
        logic       sel;
    } comb_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [4:0]  v;      // {W,M,X,D,F}
        logic        err;
        logic [31:0] stall;
        logic [31:0] flush;
    } regs_t;

    comb_t cq[$];
    regs_t rq[$];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [1:0]  m_state;
    logic [4:0]  m_v;
    int          m_wait;
    logic        m_err;
    logic [31:0] m_stall, m_flush;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_en();
        return {bus.enW, bus.enM, bus.enX, bus.enD, bus.enF};
    endfunction

    function automatic logic [4:0] dut_v();
        return {bus.validW, bus.validM, bus.validX, bus.validD, bus.validF};
    endfunction

    task automatic model_reset();
        m_state = 2'd0;
        m_v     = 5'd0;
        m_wait  = 0;
        m_err   = 1'b0;
        m_stall = 32'd0;
        m_flush = 32'd0;
    endtask

    // Drives one cycle at the falling edge, queues the expectations, then checks them.
    task automatic step(input logic run, input logic rdy, input logic st,
                        input logic rd, input logic busy);
        comb_t      c, ce;
        regs_t      r, re;
        logic [1:0] ns;
        logic [4:0] nv;
        int         nw;
        bus.run_en       = run;
        bus.imem_ready   = rdy;
        bus.stallF_req   = st;
        bus.redirect_req = rd;
        bus.dmem_busy    = busy;
        c  = '0;
        ns = m_state;
        nv = m_v;
        nw = m_wait;
        if (m_state == 2'd1 || m_state == 2'd2) begin
            if (busy) begin
                nw = (m_state == 2'd1) ? 1 : m_wait + 1;
                ns = (nw >= TMO) ? 2'd3 : 2'd2;
                m_stall++;
            end else begin
                ns    = 2'd1;
                nw    = 0;
                nv[4] = m_v[3];
                nv[3] = m_v[2];
                nv[2] = m_v[1];
                if (rd) begin
                    c.en = 5'h1f; c.pc_en = 1'b1; c.sel = 1'b1;
                    nv[1] = 1'b0; nv[0] = 1'b0;
                    m_flush++;
                end else if (st) begin
                    c.en  = 5'h1e;
                    nv[1] = 1'b0;
                    m_stall++;
                end else begin
                    c.en  = 5'h1f; c.pc_en = rdy;
                    nv[1] = m_v[0] & rdy;
                    nv[0] = rdy;
                end
            end
        end else if (m_state == 2'd0 && run) begin
            ns = 2'd1;
        end
        if (ns == 2'd3) begin
            nv    = 5'd0;
            m_err = 1'b1;
        end
        m_state = ns;
        m_v     = nv;
        m_wait  = nw;
        r.st  = m_state;
        r.v   = m_v;
        r.err = m_err;
`ifdef PIPE_PERF_CNT_EN
        r.stall = m_stall;
        r.flush = m_flush;
`else
        r.stall = 32'd0;
        r.flush = 32'd0;
`endif
        cq.push_back(c);
        rq.push_back(r);

        #1;
        ce = cq.pop_front();
        check($sformatf("c%0d.en", cyc), 64'(dut_en()), 64'(ce.en));
        check($sformatf("c%0d.pc_en", cyc), 64'(bus.pc_en), 64'(ce.pc_en));
        check($sformatf("c%0d.pc_sel_redir", cyc), 64'(bus.pc_sel_redir), 64'(ce.sel));
        @(posedge clk);
        #1;
        re = rq.pop_front();
        check($sformatf("c%0d.state", cyc), 64'(bus.state_o), 64'(re.st));
        check($sformatf("c%0d.valid", cyc), 64'(dut_v()), 64'(re.v));
        check($sformatf("c%0d.err", cyc), 64'(bus.err_timeout), 64'(re.err));
        check($sformatf("c%0d.stall_cycles", cyc), 64'(bus.stall_cycles), 64'(re.stall));
        check($sformatf("c%0d.flush_count", cyc), 64'(bus.flush_count), 64'(re.flush));
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"}, 64'(bus.state_o), 64'd0);
        check({tag, ".valid"}, 64'(dut_v()), 64'd0);
        check({tag, ".en"}, 64'(dut_en()), 64'd0);
        check({tag, ".pc_en"}, 64'(bus.pc_en), 64'd0);
        check({tag, ".pc_sel_redir"}, 64'(bus.pc_sel_redir), 64'd0);
        check({tag, ".err"}, 64'(bus.err_timeout), 64'd0);
        check({tag, ".stall_cycles"}, 64'(bus.stall_cycles), 64'd0);
        check({tag, ".flush_count"}, 64'(bus.flush_count), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run_en       = 1'b0;
        bus.imem_ready   = 1'b0;
        bus.stallF_req   = 1'b0;
        bus.redirect_req = 1'b0;
        bus.dmem_busy    = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start-up and fill: one stage becomes valid per cycle.
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        check("fill.validW", 64'(bus.validW), 64'd1);

        // Load-use stall, then redirect coinciding with a stall.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);

        // Three busy cycles, then release with a redirect pending.
        repeat (3) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);

        // Mixed traffic.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 4) == 0));
        end

        // Asynchronous reset in the middle of a memory wait.
        repeat (2) step(0, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Refill, then hold busy past the timeout.
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        repeat (TMO) step(0, 1, 0, 0, 1);
        check("timeout.state", 64'(bus.state_o), 64'd3);
        check("timeout.err", 64'(bus.err_timeout), 64'd1);
        step(1, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0);

        rst_n = 1'b0;
        #1;
        check_reset_values("final_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
